// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with run-time pattern reload.
// Optional saturating match counter is compiled in with SEQDET_MATCH_COUNT_EN.
module seq_detector_param #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = PAT_W'(4'b0110),
    parameter int                 OVERLAP = 0,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             out,
    output logic [CNT_W-1:0] count
);

    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist_r;
    logic [FILL_W-1:0] fill_r;
    logic [PAT_W-1:0]  pat_r;

    logic [PAT_W-1:0]  cand_s;
    logic              match_s;
    logic [PAT_W-2:0]  hist_nxt_s;
    logic [FILL_W-1:0] fill_nxt_s;
    logic [PAT_W-1:0]  pat_nxt_s;

    // Mealy match: candidate word is the held history plus the live input bit
    always_comb begin
        cand_s  = {hist_r, in};
        match_s = 1'b0;
        if (!reset && en && !pat_load && (fill_r == FILL_MAX) && (cand_s == pat_r)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    assign out = match_s;

    // Next-state: a pattern load wins over data and drops the partial history
    always_comb begin
        hist_nxt_s = hist_r;
        fill_nxt_s = fill_r;
        pat_nxt_s  = pat_r;
        if (pat_load) begin
            pat_nxt_s  = pat_in;
            fill_nxt_s = {FILL_W{1'b0}};
        end else if (en) begin
            hist_nxt_s = cand_s[PAT_W-2:0];
            if (match_s && (OVERLAP == 0)) begin
                fill_nxt_s = {FILL_W{1'b0}};
            end else if (fill_r == FILL_MAX) begin
                fill_nxt_s = FILL_MAX;
            end else begin
                fill_nxt_s = fill_r + FILL_W'(1);
            end
        end else begin
            hist_nxt_s = hist_r;
        end
    end

    // Detector state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_r <= {(PAT_W-1){1'b0}};
            fill_r <= {FILL_W{1'b0}};
            pat_r  <= PATTERN;
        end else begin
            hist_r <= hist_nxt_s;
            fill_r <= fill_nxt_s;
            pat_r  <= pat_nxt_s;
        end
    end

`ifdef SEQDET_MATCH_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;

    // Saturating match counter; only reset clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (match_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
`else
    assign count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench for seq_detector_param: non-overlap, overlap and
// narrow-counter instances share stimulus; counts follow SEQDET_MATCH_COUNT_EN.
module tb_seq_detector_param;

    logic       clk;
    logic       reset;
    logic       in;
    logic       en;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       out0, out1, out2;
    logic [7:0] count0, count1;
    logic [1:0] count2;

    int total;
    int bad;
    int mcnt0, mcnt1, mcnt2;

    seq_detector_param #(.OVERLAP(0)) d0 (
        .clk(clk), .reset(reset), .in(in), .en(en), .pat_load(pat_load),
        .pat_in(pat_in), .out(out0), .count(count0));

    seq_detector_param #(.OVERLAP(1)) d1 (
        .clk(clk), .reset(reset), .in(in), .en(en), .pat_load(pat_load),
        .pat_in(pat_in), .out(out1), .count(count1));

    seq_detector_param #(.OVERLAP(0), .CNT_W(2)) d2 (
        .clk(clk), .reset(reset), .in(in), .en(en), .pat_load(pat_load),
        .pat_in(pat_in), .out(out2), .count(count2));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       b;
        logic       e;
        logic       ld;
        logic [3:0] pin;
        logic       e0;
        logic       e1;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_counts();
`ifdef SEQDET_MATCH_COUNT_EN
        chk("count0", int'(count0), mcnt0);
        chk("count1", int'(count1), mcnt1);
        chk("count2", int'(count2), mcnt2);
`else
        chk("count0", int'(count0), 0);
        chk("count1", int'(count1), 0);
        chk("count2", int'(count2), 0);
`endif
    endtask

    task automatic add(input logic r, input logic b, input logic e, input logic ld,
                       input logic [3:0] pin, input logic e0, input logic e1);
        vec_t v;
        v.rst = r; v.b = b; v.e = e; v.ld = ld; v.pin = pin; v.e0 = e0; v.e1 = e1;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0; pat_load = 1'b0; in = 1'b0;
        reset = 1'b1;
        mcnt0 = 0; mcnt1 = 0; mcnt2 = 0;
        #2;
        chk("rst_out0", int'(out0), 0);
        chk("rst_out1", int'(out1), 0);
        chk_counts();
        reset = 1'b0;
    endtask

    task automatic step(input logic b, input logic e, input logic ld, input logic [3:0] pin,
                        input logic e0, input logic e1);
        @(negedge clk);
        in = b; en = e; pat_load = ld; pat_in = pin;
        #1;
        chk("out0", int'(out0), int'(e0));
        chk("out1", int'(out1), int'(e1));
        chk("out2", int'(out2), int'(e0));
        @(posedge clk);
        if (e0 && mcnt0 < 255) mcnt0++;
        if (e1 && mcnt1 < 255) mcnt1++;
        if (e0 && mcnt2 < 3)   mcnt2++;
        #1;
        chk_counts();
    endtask

    initial begin
        total = 0; bad = 0;
        mcnt0 = 0; mcnt1 = 0; mcnt2 = 0;
        reset = 1'b1; in = 1'b0; en = 1'b0; pat_load = 1'b0; pat_in = 4'b0000;
        #25;
        chk("init_out0", int'(out0), 0);
        chk("init_out2", int'(out2), 0);
        chk_counts();
        reset = 1'b0;

        // 0110110: non-overlap hits bit 4 only, overlap hits bits 4 and 7
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
        // 010010110010 without and then with a 3-cycle idle gap after bit 7
        for (int pass = 0; pass < 2; pass++) begin
            logic [11:0] s;
            s = 12'b0100_1011_0010;
            for (int i = 11; i >= 0; i--) begin
                add((i == 11) ? 1'b1 : 1'b0, s[i], 1'b1, 1'b0, 4'b0000,
                    (i == 3) ? 1'b1 : 1'b0, (i == 3) ? 1'b1 : 1'b0);
                if (pass == 1 && i == 5) begin
                    for (int g = 0; g < 3; g++)
                        add(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
                end
            end
        end
        // Reload to 1011 mid-partial 011; the discarded bit would have completed 0110
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);

        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset();
            step(tbl[k].b, tbl[k].e, tbl[k].ld, tbl[k].pin, tbl[k].e0, tbl[k].e1);
        end

        // Reload 0110 (counter kept), build 011, then reset between edges
        step(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        in = 1'b0; en = 1'b1; pat_load = 1'b0;
        #1;
        chk("pre_rst_out0", int'(out0), 1);
        chk("pre_rst_out1", int'(out1), 1);
        #2;
        reset = 1'b1;
        mcnt0 = 0; mcnt1 = 0; mcnt2 = 0;
        #1;
        chk("async_rst_out0", int'(out0), 0);
        chk("async_rst_out1", int'(out1), 0);
        chk_counts();
        #2;
        reset = 1'b0;
        #1;
        chk("post_rst_out0", int'(out0), 0);
        chk("post_rst_out1", int'(out1), 0);
        @(posedge clk);
        #1;
        chk_counts();
        step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);

        // Five back-to-back 0110 matches saturate the 2-bit counter at 3
        do_reset();
        for (int m = 0; m < 5; m++) begin
            step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
        end
`ifdef SEQDET_MATCH_COUNT_EN
        chk("sat_count2", int'(count2), 3);
        chk("five_count0", int'(count0), 5);
`else
        chk("tied_count2", int'(count2), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
